// File: rtl/serial_add_if.sv
// Bundle of request, operand, full-adder and result signals for serial_add_ctrl.
// master = surrounding environment (requester plus external full adder), slave = controller.
`timescale 1ns/1ps
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c;
  logic             fa_sum;
  logic             fa_carry;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, clr, a, b, cin, fa_sum, fa_carry,
    input  fa_a, fa_b, fa_c, busy, done, sum, cout
  );

  modport slave (
    input  start, clr, a, b, cin, fa_sum, fa_carry,
    output fa_a, fa_b, fa_c, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps an external 1-bit full adder across WIDTH
// operand bits, LSB first, and registers {cout,sum} = a + b + cin.
`timescale 1ns/1ps
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  serial_add_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_run;
  logic             w_last;
  logic             w_accept;

  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = bus.start && !bus.clr && !w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_RUN;
        S_RUN:   if (w_last)    w_next = S_DONE;
        S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Result bits are written in place, so sum is only meaningful while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (bus.clr) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_sum[r_cnt] <= bus.fa_sum;
      r_carry      <= bus.fa_carry;
      r_a_sh       <= r_a_sh >> 1;
      r_b_sh       <= r_b_sh >> 1;
      r_cnt        <= r_cnt + CNT_W'(1);
      if (w_last) r_cout <= bus.fa_carry;
    end
  end

  assign bus.fa_a = w_run & r_a_sh[0];
  assign bus.fa_b = w_run & r_b_sh[0];
  assign bus.fa_c = w_run & r_carry;
  assign bus.busy = w_run;
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule
